// File: rtl/rc4_xor.sv
// RC4 keystream combiner: buffers keystream bytes in a small FIFO and XORs them
// onto a length-framed plaintext stream, producing one registered ciphertext byte per handshake.
module rc4_xor #(
  parameter int KS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] msg_len,
  input  logic        ks_valid,
  input  logic [7:0]  ks_data,
  output logic        ks_ready,
  input  logic        pt_valid,
  input  logic [7:0]  pt_data,
  output logic        pt_ready,
  output logic        ct_valid,
  output logic [7:0]  ct_data,
  input  logic        ct_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] byte_cnt
);

  // state | meaning
  // IDLE  | waiting for start; keystream may prefill
  // RUN   | accepting plaintext until msg_len bytes taken
  // DRAIN | last ciphertext byte waiting for downstream
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int PW = $clog2(KS_DEPTH);
  localparam int CW = PW + 1;

  state_t        state;
  logic [7:0]    mem [KS_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [15:0]   len_q;
  logic          push;
  logic          pop;
  logic          ct_hs;

  assign ks_ready = (count != CW'(KS_DEPTH));
  assign pt_ready = (state == RUN) && (count != '0) && (!ct_valid || ct_ready);
  assign push     = ks_valid && ks_ready;
  assign pop      = pt_valid && pt_ready;
  assign ct_hs    = ct_valid && ct_ready;
  assign busy     = (state != IDLE);

  // Storage needs no reset: occupancy is governed entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= ks_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      len_q    <= '0;
      ct_valid <= 1'b0;
      ct_data  <= 8'h00;
      done     <= 1'b0;
      byte_cnt <= '0;
    end else begin
      done <= 1'b0;

      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      if (pop) begin
        ct_data  <= pt_data ^ mem[head];
        ct_valid <= 1'b1;
      end else if (ct_hs) begin
        ct_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            byte_cnt <= '0;
            len_q    <= msg_len;
            if (msg_len == 16'd0) done  <= 1'b1;
            else                  state <= RUN;
          end
        end
        RUN: begin
          if (pop) begin
            byte_cnt <= byte_cnt + 16'd1;
            if (byte_cnt == len_q - 16'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (ct_hs) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_xor.sv
// Randomized bench for rc4_xor: a queue-based reference of keystream FIFO,
// message framing and ciphertext stream is checked against the DUT every cycle.
module tb_rc4_xor;
  localparam int KS_DEPTH = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] msg_len = '0;
  logic        ks_valid = 1'b0;
  logic [7:0]  ks_data = '0;
  logic        ks_ready;
  logic        pt_valid = 1'b0;
  logic [7:0]  pt_data = '0;
  logic        pt_ready;
  logic        ct_valid;
  logic [7:0]  ct_data;
  logic        ct_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] byte_cnt;

  rc4_xor #(.KS_DEPTH(KS_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
    .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
    .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
    .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready),
    .busy(busy), .done(done), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model
  logic [7:0] ksq[$];
  logic [7:0] ctq[$];
  int         m_state = M_IDLE;
  int         m_len = 0;
  int         m_cnt = 0;
  bit         m_done = 0;

  // stimulus sources and observed ciphertext
  logic [7:0] ks_feed[$];
  logic [7:0] pt_feed[$];
  logic [7:0] ct_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int ks_pct, input int pt_pct, input int ct_pct,
                      input bit st, input logic [15:0] ln);
    bit e_ks_rdy, e_pt_rdy, e_ct_v, ks_hs, pt_hs, ct_hs, nd;
    int cur;
    @(negedge clk);
    ks_valid = (ks_feed.size() != 0) && (int'($urandom_range(99)) < ks_pct);
    ks_data  = ks_valid ? ks_feed[0] : 8'($urandom);
    pt_valid = (pt_feed.size() != 0) && (int'($urandom_range(99)) < pt_pct);
    pt_data  = pt_valid ? pt_feed[0] : 8'($urandom);
    ct_ready = (int'($urandom_range(99)) < ct_pct);
    start    = st;
    msg_len  = ln;
    #1;
    cur      = m_state;
    e_ks_rdy = (ksq.size() < KS_DEPTH);
    e_ct_v   = (ctq.size() != 0);
    e_pt_rdy = (cur == M_RUN) && (ksq.size() != 0) && (!e_ct_v || ct_ready);
    chk("ks_ready", ks_ready, e_ks_rdy);
    chk("pt_ready", pt_ready, e_pt_rdy);
    chk("ct_valid", ct_valid, e_ct_v);
    chk("busy", busy, cur != M_IDLE);
    chk("done", done, m_done);
    chk("byte_cnt", byte_cnt, m_cnt);
    if (e_ct_v) chk("ct_data", ct_data, ctq[0]);

    ks_hs = ks_valid && e_ks_rdy;
    pt_hs = pt_valid && e_pt_rdy;
    ct_hs = e_ct_v && ct_ready;
    nd = 0;
    if (ct_hs) begin
      ct_log.push_back(ct_data);
      void'(ctq.pop_front());
      if (cur == M_DRAIN) begin
        m_state = M_IDLE;
        nd = 1;
      end
    end
    if (pt_hs) begin
      ctq.push_back(pt_data ^ ksq.pop_front());
      void'(pt_feed.pop_front());
      m_cnt++;
      if (m_cnt == m_len) m_state = M_DRAIN;
    end
    if (ks_hs) begin
      ksq.push_back(ks_data);
      void'(ks_feed.pop_front());
    end
    if (st && cur == M_IDLE) begin
      m_cnt = 0;
      m_len = ln;
      if (ln == 0) nd = 1;
      else         m_state = M_RUN;
    end
    m_done = nd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0; ks_valid = 1'b0; pt_valid = 1'b0;
    #1;
    chk("rst_ks_ready", ks_ready, 1);
    chk("rst_pt_ready", pt_ready, 0);
    chk("rst_ct_valid", ct_valid, 0);
    chk("rst_ct_data", ct_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_byte_cnt", byte_cnt, 0);
    ksq.delete(); ctq.delete(); pt_feed.delete();
    m_state = M_IDLE; m_cnt = 0; m_len = 0; m_done = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_pt(input int n);
    for (int i = 0; i < n; i++) pt_feed.push_back(8'($urandom));
  endtask

  task automatic fill_ks(input int n);
    for (int i = 0; i < n; i++) ks_feed.push_back(8'($urandom));
  endtask

  // Starts a message of len bytes (pt_feed already loaded) and runs it to done;
  // stray starts are thrown in while busy and must be ignored.
  task automatic run_msg(input int len, input int ks_pct, input int pt_pct, input int ct_pct);
    int guard = 0;
    step(ks_pct, 0, ct_pct, 1, 16'(len));
    while (m_state != M_IDLE && guard < 3000) begin
      step(ks_pct, pt_pct, ct_pct, $urandom_range(7) == 0, 16'($urandom_range(20)));
      guard++;
    end
    chk("msg_timeout", guard < 3000, 1);
    step(ks_pct, 0, ct_pct, 0, 16'd0);
  endtask

  logic [7:0] exp_ct [4];
  logic [7:0] dir_ks [4];
  logic [7:0] dir_pt [4];

  initial begin
    exp_ct = '{8'hB2, 8'hC6, 8'h39, 8'h00};
    dir_ks = '{8'hB2, 8'h39, 8'h63, 8'h05};
    dir_pt = '{8'h00, 8'hFF, 8'h5A, 8'h05};

    do_reset();

    // known-answer message with prefilled keystream
    for (int i = 0; i < 4; i++) ks_feed.push_back(dir_ks[i]);
    for (int i = 0; i < 4; i++) step(100, 0, 100, 0, 16'd0);
    for (int i = 0; i < 4; i++) pt_feed.push_back(dir_pt[i]);
    ct_log.delete();
    run_msg(4, 0, 100, 100);
    chk("kat_ct_count", ct_log.size(), 4);
    for (int i = 0; i < 4 && i < ct_log.size(); i++) chk("kat_ct", ct_log[i], exp_ct[i]);
    chk("kat_byte_cnt", byte_cnt, 16'd4);

    // overfill: fifth keystream byte must be held back
    for (int i = 0; i < 5; i++) ks_feed.push_back(8'(8'h10 + i));
    for (int i = 0; i < 5; i++) step(100, 0, 100, 0, 16'd0);
    chk("ks_held", ks_feed.size(), 1);
    fill_pt(7); fill_ks(2);
    run_msg(7, 60, 100, 100);

    // zero-length message
    run_msg(0, 50, 100, 100);

    // starved keystream and backpressure
    fill_pt(6); fill_ks(6);
    run_msg(6, 15, 100, 30);

    // random traffic
    for (int m = 0; m < 8; m++) begin
      int len = $urandom_range(1, 12);
      fill_pt(len); fill_ks(len + $urandom_range(3));
      run_msg(len, $urandom_range(20, 100), $urandom_range(30, 100), $urandom_range(20, 100));
    end

    // abort after two bytes, then a clean message
    fill_pt(4); fill_ks(4);
    step(100, 0, 100, 1, 16'd4);
    for (int g = 0; g < 200 && m_cnt < 2; g++) step(100, 100, 100, 0, 16'd0);
    chk("abort_reached", m_cnt, 2);
    do_reset();
    step(0, 0, 100, 0, 16'd0);
    fill_pt(5); fill_ks(5);
    run_msg(5, 70, 80, 70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/rc4_xor.md
RC4_XOR -- requirements
Module: rc4_xor

Interface
REQ-001 SHALL have parameter KS_DEPTH, default 4, giving keystream FIFO depth in bytes (power of two, >=2).
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle message start request.
- msg_len  in  16  message length in bytes, captured on accepted start.
- ks_valid  in  1  keystream byte valid.
- ks_data  in  8  keystream byte (rc4 ckey).
- ks_ready  out  1  keystream byte accepted when ks_valid&ks_ready.
- pt_valid  in  1  plaintext byte valid.
- pt_data  in  8  plaintext byte.
- pt_ready  out  1  plaintext accepted when pt_valid&pt_ready.
- ct_valid  out  1  ciphertext byte valid.
- ct_data  out  8  ciphertext byte.
- ct_ready  in  1  downstream accepts ct when ct_valid&ct_ready.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at message end.
- byte_cnt  out  16  plaintext bytes accepted in current message.
REQ-003 Clock and reset SHALL be one clock domain clk, reset asynchronous active-high on rst.

Function
REQ-004 Keystream FIFO: KS_DEPTH entries, head/tail pointers wrap modulo KS_DEPTH, occupancy count 0..KS_DEPTH.
REQ-005 ks_ready SHALL equal (count != KS_DEPTH) from registered count, independent of FSM state; keystream may prefill in IDLE.
REQ-006 FIFO contents SHALL persist across messages; only rst flushes it.
REQ-007 Simultaneous push and pop SHALL leave count unchanged; full blocks push, empty blocks pop; no empty-FIFO bypass.
REQ-008 FSM states IDLE, RUN, DRAIN.
REQ-009 IDLE: start with msg_len!=0 -> RUN, latch msg_len, clear byte_cnt; start with msg_len==0 -> stay IDLE, done pulse next cycle, byte_cnt cleared.
REQ-010 start SHALL be ignored outside IDLE.
REQ-011 pt_ready SHALL equal (state==RUN) & (count!=0) & (!ct_valid | ct_ready).
REQ-012 On pt handshake: ct_data <= pt_data XOR FIFO head, ct_valid <= 1, FIFO pop, byte_cnt+1; latency one cycle.
REQ-013 ct_valid SHALL clear after ct handshake unless a new byte loads same cycle; ct_data/ct_valid SHALL hold stable while ct_valid&!ct_ready.
REQ-014 RUN: pt handshake with byte_cnt==msg_len-1 -> DRAIN; no further pt accepted.
REQ-015 DRAIN: ct handshake -> IDLE with done=1 for exactly that next cycle; busy low in IDLE.
REQ-016 byte_cnt SHALL hold final value in IDLE until next accepted start.
REQ-017 Arithmetic 8-bit XOR, no carries; byte_cnt 16-bit, cannot wrap since bounded by msg_len<=65535.

Reset
REQ-018 On rst: state IDLE, count/pointers 0, ct_valid 0, ct_data 0x00, done 0, busy 0, byte_cnt 0; ks_ready 1 after reset; pt_ready 0.
REQ-019 rst mid-message SHALL abort immediately, discard FIFO and pending ct, no done pulse.

Verification
REQ-020 Prefill ks 0xB2,0x39,0x63,0x05 in IDLE; start msg_len=4; pt 0x00,0xFF,0x5A,0x05, ct_ready=1 -> ct 0xB2,0xC6,0x39,0x00, done one cycle after last ct, byte_cnt=4.
REQ-021 KS_DEPTH=4, push 5 ks bytes with no pt -> ks_ready low after 4th, 5th held until a pop; order preserved across pointer wrap.
REQ-022 ct_ready low 3 cycles with ct_valid high -> ct_data stable, pt_ready low, no byte lost or duplicated.
REQ-023 start msg_len=0 -> no pt accepted, done pulse next cycle, busy stays 0; start during RUN ignored.
REQ-024 Empty FIFO in RUN with pt_valid high -> pt_ready low until ks byte arrives, then that byte used one cycle later.
REQ-025 rst asserted after 2 of 4 bytes -> all outputs at reset values that cycle, no done, next message starts cleanly.
